// File: rtl/led_pkg.sv
// Shared constants for the LED fade stage: channel count, default PWM and
// decay settings, and small helpers for deriving counter widths.
package led_pkg;

  localparam int LED_NUM        = 8;
  localparam int PWM_BITS_DEF   = 8;
  localparam int DECAY_DIV_DEF  = 1_562_500;
  localparam int DECAY_STEP_DEF = 8;

  // Full-scale brightness for a given PWM width.
  function automatic int max_of(input int bits);
    return (1 << bits) - 1;
  endfunction

  localparam int MAX_DEF = max_of(PWM_BITS_DEF);

  // Width needed to count 0..n-1; at least one bit so a divider of 1 still builds.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_pwm_chan.sv
// One LED channel: brightness tracker with linear decay, duty latch that only
// changes at PWM period boundaries, and the registered output compare/mux.
module led_pwm_chan
  import led_pkg::*;
#(
  parameter int PWM_BITS   = PWM_BITS_DEF,
  parameter int DECAY_STEP = DECAY_STEP_DEF
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                i_led_q,
  input  logic                i_tick,
  input  logic [PWM_BITS-1:0] i_pwm_cnt,
  input  logic                i_pwm_last,
  input  logic                i_fade_en,
  output logic                o_led_out
);

  localparam logic [PWM_BITS-1:0] MAX_V  = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] STEP_V = PWM_BITS'(DECAY_STEP);

  logic [PWM_BITS-1:0] r_bright;
  logic [PWM_BITS-1:0] r_duty;
  logic                r_led_out;
  logic                w_pwm_on;

  // Brightness: a lit input forces full scale (beating a coincident tick);
  // otherwise each tick walks it down and it saturates at zero.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_bright <= '0;
    end else if (i_led_q) begin
      r_bright <= MAX_V;
    end else if (i_tick) begin
      r_bright <= (r_bright > STEP_V) ? (r_bright - STEP_V) : '0;
    end
  end

  // Duty latch: sample brightness on the last count of a period so a period
  // never sees its compare threshold change halfway through.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_duty <= '0;
    end else if (i_pwm_last) begin
      r_duty <= r_bright;
    end
  end

  // Full-scale duty must stay on for the whole period, including the MAX count.
  assign w_pwm_on = (r_duty == MAX_V) | (i_pwm_cnt < r_duty);

  // Output register: PWM waveform in fade mode, raw registered status in bypass.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_led_out <= 1'b0;
    end else begin
      r_led_out <= i_fade_en ? w_pwm_on : i_led_q;
    end
  end

  assign o_led_out = r_led_out;

endmodule

// File: rtl/led_fade_pwm.sv
// LED fade stage: registers the running-light status, runs the shared PWM
// and decay timebases, and fans them out to one fading channel per LED.
module led_fade_pwm
  import led_pkg::*;
#(
  parameter int PWM_BITS   = PWM_BITS_DEF,
  parameter int DECAY_DIV  = DECAY_DIV_DEF,
  parameter int DECAY_STEP = DECAY_STEP_DEF
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [LED_NUM-1:0] led_in,
  input  logic               fade_en,
  output logic [LED_NUM-1:0] led_out
);

  localparam int DIV_W = cnt_width(DECAY_DIV);
  localparam logic [PWM_BITS-1:0] PWM_LAST_V = {PWM_BITS{1'b1}};
  localparam logic [DIV_W-1:0]    DIV_LAST_V = DIV_W'(DECAY_DIV - 1);

  logic [LED_NUM-1:0]  r_led_in_q;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [DIV_W-1:0]    r_decay_cnt;
  logic                w_tick;
  logic                w_pwm_last;
  logic [LED_NUM-1:0]  w_led_out;

  // Input register: one stage between the upstream status and all channel logic.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_led_in_q <= '0;
    end else begin
      r_led_in_q <= led_in;
    end
  end

  // PWM timebase: free-running, wraps naturally from MAX to 0.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_pwm_cnt <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
    end
  end

  // Decay timebase: modulo-DECAY_DIV counter, independent of the PWM counter.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_decay_cnt <= '0;
    end else if (r_decay_cnt == DIV_LAST_V) begin
      r_decay_cnt <= '0;
    end else begin
      r_decay_cnt <= r_decay_cnt + 1'b1;
    end
  end

  assign w_tick     = (r_decay_cnt == DIV_LAST_V);
  assign w_pwm_last = (r_pwm_cnt == PWM_LAST_V);

  genvar gi;
  generate
    for (gi = 0; gi < LED_NUM; gi++) begin : g_chan
      led_pwm_chan #(
        .PWM_BITS   (PWM_BITS),
        .DECAY_STEP (DECAY_STEP)
      ) u_chan (
        .clk        (clk),
        .rstn       (rstn),
        .i_led_q    (r_led_in_q[gi]),
        .i_tick     (w_tick),
        .i_pwm_cnt  (r_pwm_cnt),
        .i_pwm_last (w_pwm_last),
        .i_fade_en  (fade_en),
        .o_led_out  (w_led_out[gi])
      );
    end
  endgenerate

  assign led_out = w_led_out;

endmodule

// File: tb/tb_led_fade_pwm.sv
// Self-checking bench for led_fade_pwm with a short PWM period and one decay
// tick per period, so whole fade trails fit in a few hundred cycles.
module tb_led_fade_pwm;

  localparam int PB     = 4;
  localparam int DIV    = 16;
  localparam int STEP   = 4;
  localparam int MAXV   = (1 << PB) - 1;
  localparam int PERIOD = 1 << PB;

  logic       clk     = 1'b0;
  logic       rstn    = 1'b0;
  logic [7:0] led_in  = 8'h00;
  logic       fade_en = 1'b0;
  logic [7:0] led_out;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  led_fade_pwm #(
    .PWM_BITS   (PB),
    .DECAY_DIV  (DIV),
    .DECAY_STEP (STEP)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .led_in  (led_in),
    .fade_en (fade_en),
    .led_out (led_out)
  );

  // Reference model: brightness is derived from "how many decay ticks since
  // this LED was last seen lit", rather than tracked as a decrementing value.
  logic [7:0] m_q     = '0;
  logic [7:0] m_out   = '0;
  logic [7:0] m_lit   = '0;
  int         m_ticks [8];
  int         m_duty  [8];
  int         m_cycle = 0;   // cycles since reset release

  function automatic int bright_of(input logic lit, input int ticks);
    int b;
    if (!lit) return 0;
    b = MAXV - STEP * ticks;
    return (b > 0) ? b : 0;
  endfunction

  function automatic int phase_now();
    return m_cycle % PERIOD;
  endfunction

  always @(posedge clk) begin
    if (!rstn) begin
      m_q     <= '0;
      m_out   <= '0;
      m_lit   <= '0;
      m_cycle <= 0;
      for (int i = 0; i < 8; i++) begin
        m_ticks[i] <= 0;
        m_duty[i]  <= 0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (fade_en)
          m_out[i] <= (m_duty[i] == MAXV) || ((m_cycle % PERIOD) < m_duty[i]);
        else
          m_out[i] <= m_q[i];
        if ((m_cycle % PERIOD) == PERIOD - 1)
          m_duty[i] <= bright_of(m_lit[i], m_ticks[i]);
        if (m_q[i]) begin
          m_lit[i]   <= 1'b1;
          m_ticks[i] <= 0;
        end else if ((m_cycle % DIV) == DIV - 1 && m_ticks[i] < 1000) begin
          m_ticks[i] <= m_ticks[i] + 1;
        end
      end
      m_q     <= led_in;
      m_cycle <= m_cycle + 1;
    end
  end

  // Hold reset for n cycles with all inputs quiet, then release at a falling edge.
  task automatic do_reset(input int n);
    @(negedge clk);
    rstn   = 1'b0;
    led_in = 8'h00;
    repeat (n) @(negedge clk);
    rstn = 1'b1;
  endtask

  // Count led_out[0] high cycles over one output period (aligned to the PWM phase).
  task automatic count_window(output int hi);
    int guard;
    guard = 0;
    @(negedge clk);
    while (phase_now() != 1 && guard < 2 * PERIOD) begin
      @(negedge clk);
      guard++;
    end
    hi = int'(led_out[0]);
    repeat (PERIOD - 1) begin
      @(negedge clk);
      hi += int'(led_out[0]);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rstn    = 1'b0;
    led_in  = 8'hFF;
    fade_en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_total++;
      if (led_out !== 8'h00) $display("FAIL reset_hold: cycle %0d got %h expected 00", c, led_out);
      else n_pass++;
    end
    rstn = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_total++;
      if (led_out !== 8'h00) $display("FAIL reset_release: cycle %0d got %h expected 00", c, led_out);
      else n_pass++;
    end
    $display("test_reset done");
  endtask

  task automatic test_bypass();
    fade_en = 1'b0;
    do_reset(2);
    repeat (3) @(negedge clk);
    n_total++;
    if (led_out !== 8'h00) $display("FAIL bypass_idle: got %h expected 00", led_out);
    else n_pass++;
    led_in = 8'h81;
    @(negedge clk);
    n_total++;
    if (led_out !== 8'h00) $display("FAIL bypass_early: got %h expected 00", led_out);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (led_out !== 8'h81) $display("FAIL bypass_latency: got %h expected 81", led_out);
    else n_pass++;
    $display("test_bypass done");
  endtask

  task automatic test_full_on();
    int  found;
    fade_en = 1'b1;
    do_reset(2);
    led_in = 8'h01;
    found  = -1;
    for (int c = 1; c <= 19 && found < 0; c++) begin
      @(negedge clk);
      if (led_out[0] === 1'b1) found = c;
    end
    n_total++;
    if (found < 0) $display("FAIL full_on_attack: got no light within 19 cycles, expected led_out[0]=1");
    else n_pass++;
    for (int c = 0; c < 3 * PERIOD; c++) begin
      @(negedge clk);
      n_total++;
      if (led_out !== 8'h01) $display("FAIL full_on_hold: cycle %0d got %h expected 01", c, led_out);
      else n_pass++;
    end
    $display("test_full_on done (attack %0d cycles)", found);
  endtask

  task automatic test_decay();
    int hi;
    int exp_seq [5];
    exp_seq = '{11, 7, 3, 0, 0};
    led_in = 8'h00;
    hi = PERIOD;
    for (int w = 0; w < 4 && hi == PERIOD; w++) count_window(hi);
    n_total++;
    if (hi != exp_seq[0]) $display("FAIL decay_win0: got %0d high cycles expected %0d", hi, exp_seq[0]);
    else n_pass++;
    for (int w = 1; w < 5; w++) begin
      count_window(hi);
      n_total++;
      if (hi != exp_seq[w]) $display("FAIL decay_win%0d: got %0d high cycles expected %0d", w, hi, exp_seq[w]);
      else n_pass++;
    end
    $display("test_decay done");
  endtask

  // Wait for model brightness 7 on channel 0 with the PWM phase at `ph`.
  task automatic wait_bright7(input int ph, output bit ok);
    int guard;
    guard = 0;
    ok    = 1'b0;
    while (!ok && guard < 400) begin
      @(negedge clk);
      guard++;
      if (bright_of(m_lit[0], m_ticks[0]) == 7 && phase_now() == ph) ok = 1'b1;
    end
  endtask

  task automatic test_retrigger();
    bit ok;
    int hi;
    int exp_seq [3];
    exp_seq = '{7, 16, 11};
    fade_en = 1'b1;
    do_reset(2);
    led_in = 8'h01;
    repeat (40) @(negedge clk);
    led_in = 8'h00;
    wait_bright7(PERIOD - 2, ok);
    n_total++;
    if (!ok) $display("FAIL retrig_setup: got timeout expected bright 7");
    else n_pass++;
    // One-cycle pulse so the registered status is high only on the tick edge.
    led_in = 8'h01;
    @(negedge clk);
    led_in = 8'h00;
    for (int w = 0; w < 3; w++) begin
      count_window(hi);
      n_total++;
      if (hi != exp_seq[w]) $display("FAIL retrig_win%0d: got %0d high cycles expected %0d", w, hi, exp_seq[w]);
      else n_pass++;
    end
    $display("test_retrigger done");
  endtask

  task automatic test_reset_mid_fade();
    bit ok;
    fade_en = 1'b1;
    do_reset(2);
    led_in = 8'h01;
    repeat (40) @(negedge clk);
    led_in = 8'h00;
    wait_bright7(5, ok);
    n_total++;
    if (!ok) $display("FAIL midfade_setup: got timeout expected bright 7");
    else n_pass++;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if (led_out !== 8'h00) $display("FAIL midfade_in_reset: got %h expected 00", led_out);
    else n_pass++;
    rstn = 1'b1;
    for (int c = 0; c < 4 * PERIOD; c++) begin
      @(negedge clk);
      n_total++;
      if (led_out !== 8'h00) $display("FAIL midfade_trail: cycle %0d got %h expected 00", c, led_out);
      else n_pass++;
    end
    $display("test_reset_mid_fade done");
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    fade_en = 1'b1;
    do_reset(2);
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      n_total++;
      if (led_out !== m_out) begin
        errs++;
        if (errs <= 10) $display("FAIL random_model: cycle %0d got %h expected %h", c, led_out, m_out);
      end else begin
        n_pass++;
      end
      if ($urandom_range(0, 3) == 0) led_in = 8'(1 << $urandom_range(0, 7));
      else led_in = 8'h00;
      if ($urandom_range(0, 49) == 0) fade_en = ~fade_en;
      rstn = ($urandom_range(0, 299) != 0);
    end
    rstn = 1'b1;
    $display("test_random done (%0d model mismatches)", errs);
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_full_on();
    test_decay();
    test_retrigger();
    test_reset_mid_fade();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
